ddr_responder: RTL and testbench



---
 rtl/ddr_responder.sv | 155 +++++++++++++++
 tb/tb_ddr_responder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ddr_responder.sv
// DDR-side target for the core's chip_enable/ready/operation_done channel: line-organised
// memory with 64-bit single and 512-bit burst accesses. Optional DDR_RESPONDER_STATS_EN adds counters.
module ddr_responder #(
  parameter int LINE_ADDR_WIDTH = 12,
  parameter int READ_LATENCY    = 4,
  parameter int WRITE_LATENCY   = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         ddr_chip_enable,
  input  logic [63:0]  ddr_index,
  input  logic         ddr_write_enable,
  input  logic         ddr_burst_mode,
  input  logic [511:0] ddr_write_data,
  output logic [511:0] ddr_read_data,
  output logic         ddr_operation_done,
  output logic         ddr_ready
`ifdef DDR_RESPONDER_STATS_EN
  ,
  output logic [31:0]  stat_reads,
  output logic [31:0]  stat_writes,
  output logic [31:0]  stat_dropped
`endif
);

  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                     state, state_next;
  logic [CNT_W-1:0]           cnt, cnt_next, lat_sel;
  logic                       accept, enter_done;

  logic                       req_we, req_burst;
  logic [LINE_ADDR_WIDTH-1:0] req_line;
  logic [2:0]                 req_lane;
  logic [511:0]               req_data;

  logic                       cur_we, cur_burst;
  logic [LINE_ADDR_WIDTH-1:0] cur_line;
  logic [2:0]                 cur_lane;
  logic [511:0]               cur_data;

  logic [511:0] mem [2**LINE_ADDR_WIDTH];

  logic unused_index_bits;
  assign unused_index_bits = ^{ddr_index[63:LINE_ADDR_WIDTH+6], ddr_index[2:0]};

  assign ddr_ready          = (state == IDLE);
  assign ddr_operation_done = (state == DONE);

  assign lat_sel = ddr_write_enable ? CNT_W'(WRITE_LATENCY) : CNT_W'(READ_LATENCY);

  // A latency of 1 enters DONE straight from IDLE, so the request fields feeding
  // the commit/read must come from the ports rather than the latched copy.
  always_comb begin
    if (state == IDLE) begin
      cur_we    = ddr_write_enable;
      cur_burst = ddr_burst_mode;
      cur_line  = ddr_index[LINE_ADDR_WIDTH+5:6];
      cur_lane  = ddr_index[5:3];
      cur_data  = ddr_write_data;
    end else begin
      cur_we    = req_we;
      cur_burst = req_burst;
      cur_line  = req_line;
      cur_lane  = req_lane;
      cur_data  = req_data;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    enter_done = 1'b0;
    case (state)
      IDLE: begin
        if (ddr_chip_enable) begin
          accept = 1'b1;
          if (lat_sel == CNT_W'(1)) begin
            state_next = DONE;
            enter_done = 1'b1;
          end else begin
            state_next = BUSY;
            cnt_next   = lat_sel - CNT_W'(1);
          end
        end
      end
      BUSY: begin
        if (cnt <= CNT_W'(1)) begin
          state_next = DONE;
          enter_done = 1'b1;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      ddr_read_data <= '0;
      req_we        <= 1'b0;
      req_burst     <= 1'b0;
      req_line      <= '0;
      req_lane      <= '0;
      req_data      <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        req_we    <= ddr_write_enable;
        req_burst <= ddr_burst_mode;
        req_line  <= ddr_index[LINE_ADDR_WIDTH+5:6];
        req_lane  <= ddr_index[5:3];
        req_data  <= ddr_write_data;
      end
      if (enter_done && !cur_we) begin
        if (cur_burst) ddr_read_data <= mem[cur_line];
        else           ddr_read_data <= {{448{1'b0}}, mem[cur_line][{cur_lane, 6'b0} +: 64]};
      end
    end
  end

  // Writes land on the edge that enters DONE, so a reset before then discards them.
  always_ff @(posedge clock) begin
    if (!reset && enter_done && cur_we) begin
      if (cur_burst) mem[cur_line] <= cur_data;
      else           mem[cur_line][{cur_lane, 6'b0} +: 64] <= cur_data[63:0];
    end
  end

`ifdef DDR_RESPONDER_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_reads   <= '0;
      stat_writes  <= '0;
      stat_dropped <= '0;
    end else begin
      if (state == DONE && !req_we && stat_reads != '1)  stat_reads  <= stat_reads + 32'd1;
      if (state == DONE && req_we && stat_writes != '1)  stat_writes <= stat_writes + 32'd1;
      if (ddr_chip_enable && state != IDLE && stat_dropped != '1)
        stat_dropped <= stat_dropped + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ddr_responder.sv
// Directed plus randomized bench for ddr_responder against a line-array reference model.
module tb_ddr_responder;

  localparam int RL = 4;
  localparam int WL = 2;

  logic         clock = 1'b0;
  logic         reset;
  logic         ddr_chip_enable;
  logic [63:0]  ddr_index;
  logic         ddr_write_enable;
  logic         ddr_burst_mode;
  logic [511:0] ddr_write_data;
  logic [511:0] ddr_read_data;
  logic         ddr_operation_done;
  logic         ddr_ready;
`ifdef DDR_RESPONDER_STATS_EN
  logic [31:0]  stat_reads, stat_writes, stat_dropped;
`endif

  ddr_responder #(.LINE_ADDR_WIDTH(12), .READ_LATENCY(RL), .WRITE_LATENCY(WL)) dut (
    .clock              (clock),
    .reset              (reset),
    .ddr_chip_enable    (ddr_chip_enable),
    .ddr_index          (ddr_index),
    .ddr_write_enable   (ddr_write_enable),
    .ddr_burst_mode     (ddr_burst_mode),
    .ddr_write_data     (ddr_write_data),
    .ddr_read_data      (ddr_read_data),
    .ddr_operation_done (ddr_operation_done),
    .ddr_ready          (ddr_ready)
`ifdef DDR_RESPONDER_STATS_EN
    ,
    .stat_reads         (stat_reads),
    .stat_writes        (stat_writes),
    .stat_dropped       (stat_dropped)
`endif
  );

  always #5 clock = ~clock;

  // Reference state: memory lines keyed by line number, last read payload, stat counts.
  logic [511:0] mem_m [int];
  logic [511:0] last_rd;
  int unsigned  m_reads, m_writes, m_dropped;
  int unsigned  passed, total;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // One transaction; ce stays high with junk fields for 'hold' busy cycles (hold <= latency).
  task automatic do_op(input logic we, input logic burst, input logic [63:0] idx,
                       input logic [511:0] data, input int unsigned hold);
    int unsigned  lat;
    int           line;
    int unsigned  lane;
    logic [511:0] line_v, exp_rd;
    lat  = we ? WL : RL;
    line = int'((idx >> 6) % 64'd4096);
    lane = int'((idx >> 3) % 64'd8);
    @(negedge clock);
    chk("ready_before_req", ddr_ready, 1);
    ddr_chip_enable  = 1'b1;
    ddr_write_enable = we;
    ddr_burst_mode   = burst;
    ddr_index        = idx;
    ddr_write_data   = data;
    line_v = mem_m.exists(line) ? mem_m[line] : '0;
    if (we) begin
      if (burst) line_v = data;
      else       line_v[lane*64 +: 64] = data[63:0];
      mem_m[line] = line_v;
      exp_rd = last_rd;
      m_writes++;
    end else begin
      exp_rd  = burst ? line_v : {448'b0, line_v[lane*64 +: 64]};
      last_rd = exp_rd;
      m_reads++;
    end
    for (int unsigned k = 1; k <= lat + 1; k++) begin
      @(negedge clock);
      chk(we ? "wr_done" : "rd_done", ddr_operation_done, (k == lat) ? 1 : 0);
      chk(we ? "wr_ready" : "rd_ready", ddr_ready, (k == lat + 1) ? 1 : 0);
      if (k == lat) chk(we ? "data_hold_on_write" : "read_data", ddr_read_data, exp_rd);
      if (k <= hold) begin
        ddr_chip_enable  = 1'b1;
        ddr_write_enable = 1'($urandom);
        ddr_burst_mode   = 1'($urandom);
        ddr_index        = {$urandom, $urandom};
        ddr_write_data   = rand512();
        m_dropped++;
      end else begin
        ddr_chip_enable = 1'b0;
      end
    end
  endtask

  initial begin
    logic [511:0] pat, exp;
    logic [63:0]  idx;
    logic         we, burst;
    int unsigned  lat;

    passed = 0; total = 0;
    last_rd = '0; m_reads = 0; m_writes = 0; m_dropped = 0;
    reset = 1'b1; ddr_chip_enable = 1'b0; ddr_index = '0;
    ddr_write_enable = 1'b0; ddr_burst_mode = 1'b0; ddr_write_data = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("idle_ready", ddr_ready, 1);
      chk("idle_done", ddr_operation_done, 0);
      chk("idle_rdata", ddr_read_data, '0);
    end

    for (int i = 0; i < 8; i++) do_op(1'b1, 1'b1, 64'(i) << 6, rand512(), 0);

    pat = {64{8'hA5}};
    do_op(1'b1, 1'b1, 64'h1000, pat, 0);
    do_op(1'b0, 1'b1, 64'h1000, '0, 0);
    do_op(1'b1, 1'b0, 64'h1018, {rand512() >> 64, 64'hDEADBEEF_CAFEF00D}, 0);
    do_op(1'b0, 1'b0, 64'h1018, '0, 0);
    do_op(1'b0, 1'b1, 64'h1000, '0, 0);

    // chip_enable held for six cycles: accepts at T and again at T+5.
    @(negedge clock);
    ddr_chip_enable = 1'b1; ddr_write_enable = 1'b0; ddr_burst_mode = 1'b1; ddr_index = 64'h1000;
    exp = mem_m[64];
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      chk("drop_done", ddr_operation_done, (k == 4 || k == 9) ? 1 : 0);
      chk("drop_ready", ddr_ready, (k == 5 || k == 10) ? 1 : 0);
      if (k == 4 || k == 9) chk("drop_rdata", ddr_read_data, exp);
      ddr_chip_enable = (k <= 5);
    end
    m_reads += 2; m_dropped += 4; last_rd = exp;

    // Reset one cycle after a write to line 5 is accepted.
    @(negedge clock);
    ddr_chip_enable = 1'b1; ddr_write_enable = 1'b1; ddr_burst_mode = 1'b1;
    ddr_index = 64'(5) << 6; ddr_write_data = rand512();
    @(negedge clock);
    ddr_chip_enable = 1'b0; reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    last_rd = '0; m_reads = 0; m_writes = 0; m_dropped = 0;
    chk("rst_mid_ready", ddr_ready, 1);
    chk("rst_mid_rdata", ddr_read_data, '0);
    for (int k = 0; k < 4; k++) begin
      chk("rst_mid_no_done", ddr_operation_done, 0);
      @(negedge clock);
    end
    do_op(1'b0, 1'b1, 64'(5) << 6, '0, 0);

    do_op(1'b1, 1'b1, (64'd1 << 18) + 64'h40, rand512(), 0);
    do_op(1'b0, 1'b1, 64'h40, '0, 0);

    for (int n = 0; n < 60; n++) begin
      we    = 1'($urandom);
      burst = 1'($urandom);
      idx   = {$urandom, $urandom};
      idx[17:6] = 12'($urandom_range(0, 7));
      lat   = we ? WL : RL;
      do_op(we, burst, idx, rand512(), $urandom_range(0, lat));
    end

`ifdef DDR_RESPONDER_STATS_EN
    @(negedge clock);
    chk("stat_reads", stat_reads, m_reads);
    chk("stat_writes", stat_writes, m_writes);
    chk("stat_dropped", stat_dropped, m_dropped);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
